clock_set_ctrl: RTL and testbench

Time-set and alarm controller for the HH:MM:SS BCD clock. It sequences user edits of the running time and the alarm time from two debounced buttons, and issues a load command to the timekeeping counter. It compares the live time against the alarm and drives the buzzer. It sits between the button debouncers and the counter/7-segment path, and selects which HH:MM value the display shows.

---
 rtl/clock_set_ctrl_pkg.sv | 21 ++
 rtl/clock_set_ctrl_if.sv | 41 ++++
 rtl/clock_set_ctrl_bcd_mod_inc.sv | 25 ++
 rtl/clock_set_ctrl.sv | 254 +++++++++++++++++++++++++
 tb/tb_clock_set_ctrl.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/clock_set_ctrl_pkg.sv
// clock_pkg: shared types and constants for the time-set / alarm controller.
//   state_t  - user-edit sequencing states
//   bcd8_t   - two-digit packed BCD value (tens in [7:4], units in [3:0])
//   HR_MAX   - last legal hour value before wrapping to 00
//   MIN_MAX  - last legal minute value before wrapping to 00
package clock_pkg;

    typedef enum logic [2:0] {
        RUN,
        SET_HR,
        SET_MIN,
        ALM_HR,
        ALM_MIN
    } state_t;

    typedef logic [7:0] bcd8_t;

    localparam bcd8_t HR_MAX  = 8'h23;
    localparam bcd8_t MIN_MAX = 8'h59;

endpackage

// File: rtl/clock_set_ctrl_if.sv
// clock_set_ctrl_if: bundle between the controller and its surroundings.
//   tick_1hz, btn_mode, btn_inc  - one-cycle event pulses (debouncers / timebase)
//   cur_hr, cur_min, cur_sec     - live BCD time from the timekeeping counter
//   load, ld_hr, ld_min          - load command and value for the counter
//   disp_hr, disp_min            - BCD value for the HH:MM digits
//   blank_hr, blank_min          - blink blanking of the field being edited
//   alarm_on, buzz               - alarm armed flag and buzzer drive
// Modports: master = environment side, slave = controller side.
interface clock_set_ctrl_if;
    import clock_pkg::*;

    logic  tick_1hz;
    logic  btn_mode;
    logic  btn_inc;
    bcd8_t cur_hr;
    bcd8_t cur_min;
    bcd8_t cur_sec;

    logic  load;
    bcd8_t ld_hr;
    bcd8_t ld_min;
    bcd8_t disp_hr;
    bcd8_t disp_min;
    logic  blank_hr;
    logic  blank_min;
    logic  alarm_on;
    logic  buzz;

    modport master (
        output tick_1hz, btn_mode, btn_inc, cur_hr, cur_min, cur_sec,
        input  load, ld_hr, ld_min, disp_hr, disp_min,
               blank_hr, blank_min, alarm_on, buzz
    );

    modport slave (
        input  tick_1hz, btn_mode, btn_inc, cur_hr, cur_min, cur_sec,
        output load, ld_hr, ld_min, disp_hr, disp_min,
               blank_hr, blank_min, alarm_on, buzz
    );

endinterface

// File: rtl/clock_set_ctrl_bcd_mod_inc.sv
// bcd_mod_inc: combinational two-digit BCD increment with wrap limit.
//   value  - current BCD value (assumed legal and <= limit)
//   limit  - last legal value; value==limit wraps to 8'h00
//   result - incremented BCD value
module bcd_mod_inc
    import clock_pkg::*;
(
    input  bcd8_t value,
    input  bcd8_t limit,
    output bcd8_t result
);

    // Wrap at or beyond the limit so an out-of-range value heals to 00.
    always_comb begin
        result = value;
        if (value >= limit) begin
            result = 8'h00;
        end else if (value[3:0] == 4'h9) begin
            result = {value[7:4] + 4'h1, 4'h0};
        end else begin
            result = {value[7:4], value[3:0] + 4'h1};
        end
    end

endmodule

// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl: time-set and alarm controller for the HH:MM:SS BCD clock.
// Sequences edits of the running time and the alarm from btn_mode/btn_inc,
// commands the counter to load an edited time, compares the live time with
// the alarm and drives the buzzer.
//   clk  - system clock
//   rst  - synchronous, active-high reset
//   bus  - clock_set_ctrl_if.slave (events, live time, load, display, alarm)
// Parameters: BUZZ_SECS (buzzer duration in ticks), SNOOZE_MIN (snooze only).
// Optional feature macro: SNOOZE_EN (btn_inc during buzz snoozes instead of
// cancelling; snooze logic is absent when the macro is undefined).
module clock_set_ctrl
    import clock_pkg::*;
#(
    parameter int BUZZ_SECS = 60
`ifdef SNOOZE_EN
    , parameter int SNOOZE_MIN = 5
`endif
) (
    input  logic             clk,
    input  logic             rst,
    clock_set_ctrl_if.slave  bus
);

    localparam logic [7:0] BUZZ_LOAD = 8'(BUZZ_SECS);
`ifdef SNOOZE_EN
    localparam logic [11:0] SNOOZE_TICKS = 12'(SNOOZE_MIN * 60);
`endif

    state_t     state, state_nx;
    bcd8_t      edit_hr, edit_hr_nx, edit_min, edit_min_nx;
    bcd8_t      alm_hr, alm_hr_nx, alm_min, alm_min_nx;
    bcd8_t      ld_hr, ld_hr_nx, ld_min, ld_min_nx;
    bcd8_t      disp_hr, disp_hr_nx, disp_min, disp_min_nx;
    logic       load, load_nx;
    logic       blank_hr, blank_hr_nx, blank_min, blank_min_nx;
    logic       alarm_on, alarm_on_nx;
    logic       buzz, buzz_nx;
    logic       blink_ph, blink_ph_nx;
    logic [7:0] buzz_cnt, buzz_cnt_nx;
`ifdef SNOOZE_EN
    logic        snooze_act, snooze_act_nx;
    logic [11:0] snooze_cnt, snooze_cnt_nx;
`endif

    logic  hr_field;
    logic  mode;
    logic  inc;
    logic  fire;
    bcd8_t field_val, field_lim, field_inc;

    // A single incrementer serves whichever field is being edited.
    assign hr_field  = (state == SET_HR) || (state == ALM_HR);
    assign field_val = hr_field ? edit_hr : edit_min;
    assign field_lim = hr_field ? HR_MAX : MIN_MAX;

    bcd_mod_inc u_inc (
        .value  (field_val),
        .limit  (field_lim),
        .result (field_inc)
    );

    // btn_mode wins a collision, so btn_inc is masked by it.
    assign mode = bus.btn_mode;
    assign inc  = bus.btn_inc & ~bus.btn_mode;

    // Matches are only honoured while running; edits simply miss them.
    assign fire = bus.tick_1hz && (state == RUN) && alarm_on &&
                  (bus.cur_hr == alm_hr) && (bus.cur_min == alm_min) &&
                  (bus.cur_sec == 8'h00);

    // Register bank: every output is a flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RUN;
            edit_hr    <= 8'h00;
            edit_min   <= 8'h00;
            alm_hr     <= 8'h00;
            alm_min    <= 8'h00;
            ld_hr      <= 8'h00;
            ld_min     <= 8'h00;
            disp_hr    <= 8'h00;
            disp_min   <= 8'h00;
            load       <= 1'b0;
            blank_hr   <= 1'b0;
            blank_min  <= 1'b0;
            alarm_on   <= 1'b0;
            buzz       <= 1'b0;
            blink_ph   <= 1'b0;
            buzz_cnt   <= 8'h00;
`ifdef SNOOZE_EN
            snooze_act <= 1'b0;
            snooze_cnt <= 12'h000;
`endif
        end else begin
            state      <= state_nx;
            edit_hr    <= edit_hr_nx;
            edit_min   <= edit_min_nx;
            alm_hr     <= alm_hr_nx;
            alm_min    <= alm_min_nx;
            ld_hr      <= ld_hr_nx;
            ld_min     <= ld_min_nx;
            disp_hr    <= disp_hr_nx;
            disp_min   <= disp_min_nx;
            load       <= load_nx;
            blank_hr   <= blank_hr_nx;
            blank_min  <= blank_min_nx;
            alarm_on   <= alarm_on_nx;
            buzz       <= buzz_nx;
            blink_ph   <= blink_ph_nx;
            buzz_cnt   <= buzz_cnt_nx;
`ifdef SNOOZE_EN
            snooze_act <= snooze_act_nx;
            snooze_cnt <= snooze_cnt_nx;
`endif
        end
    end

    // Next-state logic. Order matters: countdowns first, then button
    // handling may override them, and an alarm match has the final say.
    // Display and blanking are derived from the next values so that a
    // button or tick shows up on the very next edge.
    always_comb begin
        state_nx     = state;
        edit_hr_nx   = edit_hr;
        edit_min_nx  = edit_min;
        alm_hr_nx    = alm_hr;
        alm_min_nx   = alm_min;
        ld_hr_nx     = ld_hr;
        ld_min_nx    = ld_min;
        load_nx      = 1'b0;
        alarm_on_nx  = alarm_on;
        buzz_nx      = buzz;
        buzz_cnt_nx  = buzz_cnt;
        blink_ph_nx  = blink_ph ^ bus.tick_1hz;
`ifdef SNOOZE_EN
        snooze_act_nx = snooze_act;
        snooze_cnt_nx = snooze_cnt;
`endif

        if (buzz && bus.tick_1hz) begin
            if (buzz_cnt <= 8'd1) begin
                buzz_nx     = 1'b0;
                buzz_cnt_nx = 8'h00;
            end else begin
                buzz_cnt_nx = buzz_cnt - 8'd1;
            end
        end

`ifdef SNOOZE_EN
        // An expiry outside RUN is dropped, like any other missed match.
        if (snooze_act && bus.tick_1hz) begin
            if (snooze_cnt <= 12'd1) begin
                snooze_act_nx = 1'b0;
                if (state == RUN) begin
                    buzz_nx     = 1'b1;
                    buzz_cnt_nx = BUZZ_LOAD;
                end
            end else begin
                snooze_cnt_nx = snooze_cnt - 12'd1;
            end
        end
`endif

        if (buzz) begin
            // A press while buzzing only silences; it does nothing else.
`ifdef SNOOZE_EN
            if (mode) begin
                buzz_nx       = 1'b0;
                snooze_act_nx = 1'b0;
            end else if (inc) begin
                buzz_nx       = 1'b0;
                snooze_act_nx = 1'b1;
                snooze_cnt_nx = SNOOZE_TICKS;
            end
`else
            if (mode || inc) begin
                buzz_nx = 1'b0;
            end
`endif
        end else if (mode) begin
`ifdef SNOOZE_EN
            snooze_act_nx = 1'b0;
`endif
            case (state)
                RUN: begin
                    edit_hr_nx  = bus.cur_hr;
                    edit_min_nx = bus.cur_min;
                    state_nx    = SET_HR;
                end
                SET_HR: begin
                    state_nx = SET_MIN;
                end
                SET_MIN: begin
                    load_nx     = 1'b1;
                    ld_hr_nx    = edit_hr;
                    ld_min_nx   = edit_min;
                    edit_hr_nx  = alm_hr;
                    edit_min_nx = alm_min;
                    state_nx    = ALM_HR;
                end
                ALM_HR: begin
                    state_nx = ALM_MIN;
                end
                ALM_MIN: begin
                    alm_hr_nx  = edit_hr;
                    alm_min_nx = edit_min;
                    state_nx   = RUN;
                end
                default: begin
                    state_nx = RUN;
                end
            endcase
        end else if (inc) begin
            if (state == RUN) begin
`ifdef SNOOZE_EN
                if (alarm_on) begin
                    snooze_act_nx = 1'b0;
                end
`endif
                alarm_on_nx = ~alarm_on;
            end else if (hr_field) begin
                edit_hr_nx = field_inc;
            end else begin
                edit_min_nx = field_inc;
            end
        end

        if (fire) begin
            buzz_nx     = 1'b1;
            buzz_cnt_nx = BUZZ_LOAD;
        end

        if (state_nx == RUN) begin
            disp_hr_nx  = bus.cur_hr;
            disp_min_nx = bus.cur_min;
        end else begin
            disp_hr_nx  = edit_hr_nx;
            disp_min_nx = edit_min_nx;
        end
        blank_hr_nx  = blink_ph_nx && ((state_nx == SET_HR)  || (state_nx == ALM_HR));
        blank_min_nx = blink_ph_nx && ((state_nx == SET_MIN) || (state_nx == ALM_MIN));
    end

    assign bus.load      = load;
    assign bus.ld_hr     = ld_hr;
    assign bus.ld_min    = ld_min;
    assign bus.disp_hr   = disp_hr;
    assign bus.disp_min  = disp_min;
    assign bus.blank_hr  = blank_hr;
    assign bus.blank_min = blank_min;
    assign bus.alarm_on  = alarm_on;
    assign bus.buzz      = buzz;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// tb_clock_set_ctrl: self-checking bench for clock_set_ctrl.
// The bench plays the timekeeping counter (time kept as seconds of day) and
// predicts every output with a decimal-arithmetic model of the controller.
// Build with SNOOZE_EN defined to also cover the snooze behaviour.
module tb_clock_set_ctrl;
    import clock_pkg::*;

    localparam int BUZZ_SECS = 60;
`ifdef SNOOZE_EN
    localparam int SNOOZE_TICKS = 5 * 60;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    clock_set_ctrl_if bus ();

    clock_set_ctrl #(.BUZZ_SECS(BUZZ_SECS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    // Counter emulation
    int t_sec     = 0;
    bit load_pend = 0;
    int load_val  = 0;

    // Reference model (phase 0..4 = RUN, SET_HR, SET_MIN, ALM_HR, ALM_MIN)
    int m_ph, m_eh, m_em, m_ah, m_am, m_ld_h, m_ld_m, m_dh, m_dm;
    int m_buzz_left, m_snz;
    bit m_al_on, m_blink, m_load;

    function automatic logic [7:0] to_bcd(input int v);
        return 8'((v / 10) * 16 + (v % 10));
    endfunction

    task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic drive_time();
        bus.cur_hr  = to_bcd(t_sec / 3600);
        bus.cur_min = to_bcd((t_sec / 60) % 60);
        bus.cur_sec = to_bcd(t_sec % 60);
    endtask

    task automatic model_reset();
        m_ph = 0; m_eh = 0; m_em = 0; m_ah = 0; m_am = 0;
        m_ld_h = 0; m_ld_m = 0; m_dh = 0; m_dm = 0;
        m_buzz_left = 0; m_snz = 0;
        m_al_on = 0; m_blink = 0; m_load = 0;
    endtask

    task automatic model_step(input bit m, input bit i, input bit tk);
        int h  = t_sec / 3600;
        int mi = (t_sec / 60) % 60;
        int s  = t_sec % 60;
        bit was_buzz = (m_buzz_left > 0);
        bit fire = tk && (m_ph == 0) && m_al_on && (h == m_ah) && (mi == m_am) && (s == 0);
        m_load  = 0;
        m_blink = m_blink ^ tk;
        if (was_buzz && tk) m_buzz_left--;
`ifdef SNOOZE_EN
        if (m_snz > 0 && tk) begin
            m_snz--;
            if (m_snz == 0 && m_ph == 0) m_buzz_left = BUZZ_SECS;
        end
`endif
        if (was_buzz) begin
            if (m || i) m_buzz_left = 0;
`ifdef SNOOZE_EN
            if (m) m_snz = 0;
            else if (i) m_snz = SNOOZE_TICKS;
`endif
        end else if (m) begin
`ifdef SNOOZE_EN
            m_snz = 0;
`endif
            case (m_ph)
                0: begin m_eh = h; m_em = mi; end
                2: begin
                    m_load = 1; m_ld_h = m_eh; m_ld_m = m_em;
                    m_eh = m_ah; m_em = m_am;
                end
                4: begin m_ah = m_eh; m_am = m_em; end
                default: ;
            endcase
            m_ph = (m_ph + 1) % 5;
        end else if (i) begin
            if (m_ph == 0) begin
`ifdef SNOOZE_EN
                if (m_al_on) m_snz = 0;
`endif
                m_al_on = !m_al_on;
            end else if (m_ph == 1 || m_ph == 3) begin
                m_eh = (m_eh + 1) % 24;
            end else begin
                m_em = (m_em + 1) % 60;
            end
        end
        if (fire) m_buzz_left = BUZZ_SECS;
        if (m_ph == 0) begin m_dh = h; m_dm = mi; end
        else begin m_dh = m_eh; m_dm = m_em; end
    endtask

    task automatic check_all();
        check_output("load", bus.load, m_load);
        if (m_load) begin
            check_output("ld_hr", bus.ld_hr, to_bcd(m_ld_h));
            check_output("ld_min", bus.ld_min, to_bcd(m_ld_m));
        end
        check_output("disp_hr", bus.disp_hr, to_bcd(m_dh));
        check_output("disp_min", bus.disp_min, to_bcd(m_dm));
        check_output("blank_hr", bus.blank_hr, m_blink && (m_ph == 1 || m_ph == 3));
        check_output("blank_min", bus.blank_min, m_blink && (m_ph == 2 || m_ph == 4));
        check_output("alarm_on", bus.alarm_on, m_al_on);
        check_output("buzz", bus.buzz, m_buzz_left > 0);
    endtask

    task automatic apply_stimulus(input bit m, input bit i, input bit tk);
        if (load_pend) begin
            t_sec = load_val;
            load_pend = 0;
        end else if (tk) begin
            t_sec = (t_sec + 1) % 86400;
        end
        drive_time();
        bus.btn_mode = m;
        bus.btn_inc  = i;
        bus.tick_1hz = tk;
        @(posedge clk);
        #1;
        model_step(m, i, tk);
        bus.btn_mode = 1'b0;
        bus.btn_inc  = 1'b0;
        bus.tick_1hz = 1'b0;
        if (m_load) begin
            load_pend = 1;
            load_val  = m_ld_h * 3600 + m_ld_m * 60;
        end
        check_all();
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        bus.btn_mode = 1'b0;
        bus.btn_inc  = 1'b0;
        bus.tick_1hz = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
            model_reset();
            check_all();
            check_output("rst_ld_hr", bus.ld_hr, 8'h00);
        end
        rst = 1'b0;
    endtask

    initial begin
        bus.btn_mode = 1'b0;
        bus.btn_inc  = 1'b0;
        bus.tick_1hz = 1'b0;
        drive_time();
        do_reset(2);

        // Edit and load: 10:42:17 -> 13:02
        t_sec = 10 * 3600 + 42 * 60 + 17;
        apply_stimulus(0, 0, 0);
        apply_stimulus(1, 0, 0);
        repeat (3) apply_stimulus(0, 1, 0);
        apply_stimulus(1, 0, 0);
        repeat (20) apply_stimulus(0, 1, 0);
        apply_stimulus(1, 0, 0);
        check_output("tp_load", bus.load, 1);
        check_output("tp_ld_hr", bus.ld_hr, 8'h13);
        check_output("tp_ld_min", bus.ld_min, 8'h02);
        check_output("tp_alm_disp", bus.disp_hr, 8'h00);
        apply_stimulus(0, 0, 0);
        check_output("tp_load_once", bus.load, 0);

        // Wrap in ALM_HR / ALM_MIN
        repeat (23) apply_stimulus(0, 1, 0);
        check_output("hr_23", bus.disp_hr, 8'h23);
        apply_stimulus(0, 1, 0);
        check_output("wrap_hr", bus.disp_hr, 8'h00);
        apply_stimulus(1, 0, 0);
        repeat (59) apply_stimulus(0, 1, 0);
        check_output("min_59", bus.disp_min, 8'h59);
        apply_stimulus(0, 1, 0);
        check_output("wrap_min", bus.disp_min, 8'h00);
        check_output("no_carry", bus.disp_hr, 8'h00);
        apply_stimulus(1, 0, 0);

        // Alarm 07:30, armed
        repeat (3) apply_stimulus(1, 0, 0);
        repeat (7) apply_stimulus(0, 1, 0);
        apply_stimulus(1, 0, 0);
        repeat (30) apply_stimulus(0, 1, 0);
        apply_stimulus(1, 0, 0);
        apply_stimulus(0, 1, 0);
        check_output("armed", bus.alarm_on, 1);

        t_sec = 7 * 3600 + 29 * 60 + 58;
        apply_stimulus(0, 0, 0);
        apply_stimulus(0, 0, 1);
        check_output("buzz_early", bus.buzz, 0);
        apply_stimulus(0, 0, 1);
        check_output("buzz_rise", bus.buzz, 1);
        for (int k = 1; k <= BUZZ_SECS; k++) begin
            apply_stimulus(0, 0, 0);
            apply_stimulus(0, 0, 1);
            if (k == BUZZ_SECS - 1) check_output("buzz_hold", bus.buzz, 1);
        end
        check_output("buzz_fall", bus.buzz, 0);

        // Cancel with btn_mode
        t_sec = 7 * 3600 + 29 * 60 + 59;
        apply_stimulus(0, 0, 1);
        apply_stimulus(0, 0, 1);
        apply_stimulus(1, 0, 0);
        check_output("cancel_mode", bus.buzz, 0);
        check_output("cancel_stay_run", bus.disp_hr, 8'h07);
        check_output("cancel_no_blank", bus.blank_hr, 0);

        // btn_inc during buzz
        t_sec = 7 * 3600 + 29 * 60 + 59;
        apply_stimulus(0, 0, 1);
        apply_stimulus(0, 1, 0);
        check_output("cancel_inc", bus.buzz, 0);
        check_output("cancel_inc_armed", bus.alarm_on, 1);
`ifdef SNOOZE_EN
        for (int k = 1; k <= SNOOZE_TICKS; k++) begin
            apply_stimulus(0, 0, 1);
            if (k == SNOOZE_TICKS - 1) check_output("snooze_wait", bus.buzz, 0);
        end
        check_output("snooze_return", bus.buzz, 1);
        apply_stimulus(1, 0, 0);
        check_output("snooze_cancel", bus.buzz, 0);
`endif

        // Collision in SET_HR, then reset in SET_MIN
        apply_stimulus(1, 0, 0);
        apply_stimulus(1, 1, 0);
        check_output("collision_hr", bus.disp_hr, to_bcd(t_sec / 3600));
        do_reset(1);
        check_output("rst_no_load", bus.load, 0);
        check_output("rst_disarm", bus.alarm_on, 0);
        apply_stimulus(0, 0, 0);
        check_output("post_rst_load", bus.load, 0);

        // Randomized phase
        t_sec = 23 * 3600 + 59 * 60 + 30;
        for (int n = 0; n < 3000; n++) begin
            bit rm, ri, rt;
            rm = ($urandom_range(15) == 0);
            ri = ($urandom_range(5) == 0);
            rt = ($urandom_range(2) == 0);
            if ($urandom_range(299) == 0)
                t_sec = (m_ah * 3600 + m_am * 60 - 2 + 86400) % 86400;
            apply_stimulus(rm, ri, rt);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
